// File: rtl/reset_sequencer_if.sv
// Control/status bundle between the PS configuration side and the reset sequencer.
// The master side drives the configuration and event bits, and the slave side
// (the sequencer) returns the reset nets and status.
interface reset_sequencer_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 start;
  logic                 abort;
  logic                 trigger_in;
  logic                 fault;
  logic [CNT_WIDTH-1:0] dac_delay;
  logic [CNT_WIDTH-1:0] adc_delay;
  logic [CNT_WIDTH-1:0] run_length;
  logic                 dac_aresetn;
  logic                 ram_aresetn;
  logic                 busy;
  logic                 done;
  logic                 fault_sts;
  logic [2:0]           state_sts;
  logic [CNT_WIDTH-1:0] run_count;

  modport master (
    output start, abort, trigger_in, fault, dac_delay, adc_delay, run_length,
    input  dac_aresetn, ram_aresetn, busy, done, fault_sts, state_sts, run_count
  );

  modport slave (
    input  start, abort, trigger_in, fault, dac_delay, adc_delay, run_length,
    output dac_aresetn, ram_aresetn, busy, done, fault_sts, state_sts, run_count
  );
endinterface

// File: rtl/reset_sequencer.sv
// Staged reset release for the DAC path and the RAM writer after an acquisition
// trigger: arm -> wait trigger -> release DACs -> delay -> release RAM writer ->
// run N cycles -> stop. Watchdog fault or abort drops both resets immediately.
// SYNC_STAGES legal range is 2..4.
module reset_sequencer #(
  parameter int CNT_WIDTH   = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             peripheral_aresetn,
  reset_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_ARMED    = 3'd1,
    S_WAIT_DAC = 3'd2,
    S_WAIT_ADC = 3'd3,
    S_RUN      = 3'd4,
    S_DONE     = 3'd5,
    S_FAULT    = 3'd6
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH:0]   INC_ONE  = {{CNT_WIDTH{1'b0}}, 1'b1};

  state_t                 r_state;
  state_t                 w_next;
  logic [SYNC_STAGES-1:0] r_trig_sync;
  logic                   r_trig_d;
  logic                   r_start_d;
  logic                   w_start_edge;
  logic                   w_trig_edge;

  logic [CNT_WIDTH-1:0]   r_cnt;
  logic [CNT_WIDTH-1:0]   r_run_count;
  logic [CNT_WIDTH-1:0]   r_dac_delay_l;
  logic [CNT_WIDTH-1:0]   r_adc_delay_l;
  logic [CNT_WIDTH-1:0]   r_run_length_l;

  // One bit wider than the counters so an all-ones delay cannot wrap the compare.
  logic [CNT_WIDTH:0]     w_cnt_inc;
  logic [CNT_WIDTH:0]     w_run_inc;
  logic                   w_dac_done;
  logic                   w_adc_done;
  logic                   w_run_done;

  logic                   r_dac_aresetn;
  logic                   r_ram_aresetn;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_fault_sts;

  assign w_start_edge = bus.start & ~r_start_d;
  assign w_trig_edge  = r_trig_sync[SYNC_STAGES-1] & ~r_trig_d;

  assign w_cnt_inc  = {1'b0, r_cnt} + INC_ONE;
  assign w_run_inc  = {1'b0, r_run_count} + INC_ONE;
  assign w_dac_done = (w_cnt_inc >= {1'b0, r_dac_delay_l});
  assign w_adc_done = (w_cnt_inc >= {1'b0, r_adc_delay_l});
  assign w_run_done = (r_run_length_l != CNT_ZERO) && (w_run_inc >= {1'b0, r_run_length_l});

  // Trigger synchronizer plus the delayed copies used for edge detection.
  // The start copy resets high so a start level held through reset is not
  // mistaken for a fresh arming edge.
  always_ff @(posedge clk or negedge peripheral_aresetn) begin
    if (!peripheral_aresetn) begin
      r_trig_sync <= {SYNC_STAGES{1'b0}};
      r_trig_d    <= 1'b0;
      r_start_d   <= 1'b1;
    end else begin
      r_trig_sync <= {r_trig_sync[SYNC_STAGES-2:0], bus.trigger_in};
      r_trig_d    <= r_trig_sync[SYNC_STAGES-1];
      r_start_d   <= bus.start;
    end
  end

  // Next-state selection: abort beats fault beats the normal sequence.
  always_comb begin
    w_next = r_state;
    if (bus.abort) begin
      w_next = S_IDLE;
    end else if (bus.fault && (r_state != S_IDLE)) begin
      w_next = S_FAULT;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_edge) w_next = S_ARMED;
          else              w_next = S_IDLE;
        end
        S_ARMED: begin
          if (w_trig_edge) w_next = S_WAIT_DAC;
          else             w_next = S_ARMED;
        end
        S_WAIT_DAC: begin
          if (w_dac_done) w_next = S_WAIT_ADC;
          else            w_next = S_WAIT_DAC;
        end
        S_WAIT_ADC: begin
          if (w_adc_done) w_next = S_RUN;
          else            w_next = S_WAIT_ADC;
        end
        S_RUN: begin
          if (w_run_done) w_next = S_DONE;
          else            w_next = S_RUN;
        end
        S_DONE: begin
          if (!bus.start) w_next = S_IDLE;
          else            w_next = S_DONE;
        end
        S_FAULT: begin
          if (!bus.start) w_next = S_IDLE;
          else            w_next = S_FAULT;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Sequencer state, delay counters, latched configuration and outputs decoded
  // from the next state so they switch on the same edge as the state.
  always_ff @(posedge clk or negedge peripheral_aresetn) begin
    if (!peripheral_aresetn) begin
      r_state        <= S_IDLE;
      r_cnt          <= CNT_ZERO;
      r_run_count    <= CNT_ZERO;
      r_dac_delay_l  <= CNT_ZERO;
      r_adc_delay_l  <= CNT_ZERO;
      r_run_length_l <= CNT_ZERO;
      r_dac_aresetn  <= 1'b0;
      r_ram_aresetn  <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_fault_sts    <= 1'b0;
    end else begin
      r_state <= w_next;

      // Configuration is frozen at arming time.
      if ((r_state == S_IDLE) && (w_next == S_ARMED)) begin
        r_dac_delay_l  <= bus.dac_delay;
        r_adc_delay_l  <= bus.adc_delay;
        r_run_length_l <= bus.run_length;
      end

      // Dwell counter only advances while staying in a wait state.
      if (((r_state == S_WAIT_DAC) && (w_next == S_WAIT_DAC)) ||
          ((r_state == S_WAIT_ADC) && (w_next == S_WAIT_ADC))) begin
        r_cnt <= r_cnt + CNT_ONE;
      end else begin
        r_cnt <= CNT_ZERO;
      end

      // Run counter: cleared on abort and on arming, frozen outside RUN.
      if (bus.abort || ((r_state == S_IDLE) && (w_next == S_ARMED))) begin
        r_run_count <= CNT_ZERO;
      end else if ((r_state == S_RUN) && ((w_next == S_RUN) || (w_next == S_DONE)) &&
                   (r_run_count != CNT_MAX)) begin
        r_run_count <= w_run_inc[CNT_WIDTH-1:0];
      end else begin
        r_run_count <= r_run_count;
      end

      r_dac_aresetn <= (w_next == S_WAIT_ADC) || (w_next == S_RUN);
      r_ram_aresetn <= (w_next == S_RUN);
      r_busy        <= (w_next == S_ARMED) || (w_next == S_WAIT_DAC) ||
                       (w_next == S_WAIT_ADC) || (w_next == S_RUN);
      r_done        <= (w_next == S_DONE);
      r_fault_sts   <= (w_next == S_FAULT);
    end
  end

  assign bus.dac_aresetn = r_dac_aresetn;
  assign bus.ram_aresetn = r_ram_aresetn;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.fault_sts   = r_fault_sts;
  assign bus.state_sts   = r_state;
  assign bus.run_count   = r_run_count;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed scenarios with literal expectations, plus a
// cycle-level behavioural model (countdown dwell, trigger seen S cycles late)
// compared against every DUT output on each falling clock edge.
module tb_reset_sequencer;
  localparam int CW = 32;
  localparam int S  = 2;

  logic clk;
  logic rst_n;

  reset_sequencer_if #(.CNT_WIDTH(CW)) bus ();

  reset_sequencer #(.CNT_WIDTH(CW), .SYNC_STAGES(S)) dut (
    .clk                (clk),
    .peripheral_aresetn (rst_n),
    .bus                (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [2:0]    st;
    logic [CW:0]   left;
    logic [CW-1:0] runcnt;
    logic [CW-1:0] dl;
    logic [CW-1:0] al;
    logic [CW-1:0] rl;
    logic          sprev;
    logic [3:0]    th;     // th[k] = trigger pin sampled k+1 edges ago
  } mstate_t;

  localparam mstate_t M_RESET = '{st: 3'd0, left: '0, runcnt: '0, dl: '0, al: '0,
                                  rl: '0, sprev: 1'b1, th: 4'd0};

  mstate_t m;

  function automatic logic [CW:0] atleast1(input logic [CW-1:0] d);
    if (d == '0) return {{CW{1'b0}}, 1'b1};
    else         return {1'b0, d};
  endfunction

  function automatic mstate_t model_next(input mstate_t cur, input logic st_i, input logic ab,
                                         input logic tr, input logic fl, input logic [CW-1:0] dd,
                                         input logic [CW-1:0] ad, input logic [CW-1:0] rl);
    mstate_t n;
    logic    ev_s;
    logic    ev_t;
    n    = cur;
    ev_s = st_i & ~cur.sprev;
    ev_t = cur.th[S-1] & ~cur.th[S];
    n.sprev = st_i;
    n.th    = {cur.th[2:0], tr};
    if (ab) begin
      n.st = 3'd0; n.runcnt = '0; n.left = '0;
    end else if (fl && cur.st != 3'd0) begin
      n.st = 3'd6;
    end else begin
      case (cur.st)
        3'd0: if (ev_s) begin
          n.st = 3'd1; n.dl = dd; n.al = ad; n.rl = rl; n.runcnt = '0;
        end
        3'd1: if (ev_t) begin n.st = 3'd2; n.left = atleast1(cur.dl); end
        3'd2: begin
          n.left = cur.left - 1'b1;
          if (n.left == '0) begin n.st = 3'd3; n.left = atleast1(cur.al); end
        end
        3'd3: begin
          n.left = cur.left - 1'b1;
          if (n.left == '0) n.st = 3'd4;
        end
        3'd4: begin
          if (cur.rl != '0 && ({1'b0, cur.runcnt} + 1 >= {1'b0, cur.rl})) n.st = 3'd5;
          if (cur.runcnt != {CW{1'b1}}) n.runcnt = cur.runcnt + 1'b1;
        end
        3'd5: if (!st_i) n.st = 3'd0;
        3'd6: if (!st_i) n.st = 3'd0;
        default: n.st = 3'd0;
      endcase
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= M_RESET;
    else        m <= model_next(m, bus.start, bus.abort, bus.trigger_in, bus.fault,
                                bus.dac_delay, bus.adc_delay, bus.run_length);
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    chk("model.state",     {61'd0, bus.state_sts}, {61'd0, m.st});
    chk("model.dac_rstn",  {63'd0, bus.dac_aresetn}, {63'd0, (m.st == 3'd3 || m.st == 3'd4)});
    chk("model.ram_rstn",  {63'd0, bus.ram_aresetn}, {63'd0, (m.st == 3'd4)});
    chk("model.busy",      {63'd0, bus.busy}, {63'd0, (m.st >= 3'd1 && m.st <= 3'd4)});
    chk("model.done",      {63'd0, bus.done}, {63'd0, (m.st == 3'd5)});
    chk("model.fault_sts", {63'd0, bus.fault_sts}, {63'd0, (m.st == 3'd6)});
    chk("model.run_count", {32'd0, bus.run_count}, {32'd0, m.runcnt});
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [63:0] cur_sig(input int sel);
    case (sel)
      0:       return {61'd0, bus.state_sts};
      1:       return {63'd0, bus.dac_aresetn};
      2:       return {63'd0, bus.ram_aresetn};
      default: return {32'd0, bus.run_count};
    endcase
  endfunction

  // Step until the selected output equals val; n returns the number of steps taken.
  task automatic wait_for(input string name, input int sel, input logic [63:0] val,
                          input int budget, output int n);
    n = 0;
    while (cur_sig(sel) != val && n < budget) begin
      step();
      n++;
    end
    chk(name, cur_sig(sel), val);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.trigger_in = 1'b0;
    bus.fault      = 1'b0;
    bus.dac_delay  = 32'd0;
    bus.adc_delay  = 32'd0;
    bus.run_length = 32'd0;

    fork
      forever begin
        @(negedge clk);
        compare_model();
      end
    join_none

    repeat (3) step();
    chk("reset.state", {61'd0, bus.state_sts}, 64'd0);
    chk("reset.dac",   {63'd0, bus.dac_aresetn}, 64'd0);
    chk("reset.ram",   {63'd0, bus.ram_aresetn}, 64'd0);
    chk("reset.busy",  {63'd0, bus.busy}, 64'd0);
    rst_n = 1'b1;
    repeat (3) step();

    // Sequence timing 5 / 3 / 10
    bus.dac_delay = 32'd5; bus.adc_delay = 32'd3; bus.run_length = 32'd10;
    bus.start = 1'b1; step();
    chk("t1.armed", {61'd0, bus.state_sts}, 64'd1);
    bus.trigger_in = 1'b1;
    wait_for("t1.to_wait_dac", 0, 64'd2, 20, n);
    chk("t1.trig_latency", n, 64'd3);
    wait_for("t1.dac_release", 1, 64'd1, 20, n);
    chk("t1.dac_dwell", n, 64'd5);
    wait_for("t1.ram_release", 2, 64'd1, 20, n);
    chk("t1.adc_dwell", n, 64'd3);
    wait_for("t1.to_done", 0, 64'd5, 40, n);
    chk("t1.run_cycles", n, 64'd10);
    chk("t1.run_count", {32'd0, bus.run_count}, 64'd10);
    chk("t1.done_dac", {63'd0, bus.dac_aresetn}, 64'd0);
    chk("t1.done_ram", {63'd0, bus.ram_aresetn}, 64'd0);
    chk("t1.done_flag", {63'd0, bus.done}, 64'd1);
    repeat (3) step();
    chk("t1.done_hold", {61'd0, bus.state_sts}, 64'd5);
    bus.start = 1'b0; step();
    chk("t1.idle", {61'd0, bus.state_sts}, 64'd0);
    bus.trigger_in = 1'b0;
    repeat (4) step();

    // Zero delays, endless run until abort
    bus.dac_delay = 32'd0; bus.adc_delay = 32'd0; bus.run_length = 32'd0;
    bus.start = 1'b1; step();
    bus.trigger_in = 1'b1;
    wait_for("t2.to_wait_dac", 0, 64'd2, 20, n);
    wait_for("t2.to_wait_adc", 0, 64'd3, 20, n);
    chk("t2.dac_dwell", n, 64'd1);
    wait_for("t2.to_run", 0, 64'd4, 20, n);
    chk("t2.adc_dwell", n, 64'd1);
    repeat (1000) step();
    chk("t2.still_run", {61'd0, bus.state_sts}, 64'd4);
    chk("t2.run_count", {32'd0, bus.run_count}, 64'd1000);
    bus.abort = 1'b1; step();
    chk("t2.abort_state", {61'd0, bus.state_sts}, 64'd0);
    chk("t2.abort_dac", {63'd0, bus.dac_aresetn}, 64'd0);
    chk("t2.abort_ram", {63'd0, bus.ram_aresetn}, 64'd0);
    chk("t2.abort_cnt", {32'd0, bus.run_count}, 64'd0);
    bus.abort = 1'b0; bus.start = 1'b0; bus.trigger_in = 1'b0;
    repeat (4) step();

    // Fault in RUN at run_count = 4
    bus.dac_delay = 32'd1; bus.adc_delay = 32'd1; bus.run_length = 32'd100;
    bus.start = 1'b1; step();
    bus.trigger_in = 1'b1;
    wait_for("t3.rc4", 3, 64'd4, 40, n);
    bus.fault = 1'b1; step();
    chk("t3.fault_state", {61'd0, bus.state_sts}, 64'd6);
    chk("t3.fault_sts", {63'd0, bus.fault_sts}, 64'd1);
    chk("t3.fault_dac", {63'd0, bus.dac_aresetn}, 64'd0);
    chk("t3.fault_ram", {63'd0, bus.ram_aresetn}, 64'd0);
    chk("t3.fault_cnt", {32'd0, bus.run_count}, 64'd4);
    bus.fault = 1'b0; repeat (2) step();
    chk("t3.fault_hold", {61'd0, bus.state_sts}, 64'd6);
    bus.start = 1'b0; step();
    chk("t3.fault_exit", {61'd0, bus.state_sts}, 64'd0);
    bus.trigger_in = 1'b0;
    repeat (4) step();

    // Spurious events
    bus.trigger_in = 1'b1; repeat (4) step();
    bus.trigger_in = 1'b0; repeat (4) step();
    chk("t4.idle_trig", {61'd0, bus.state_sts}, 64'd0);
    bus.dac_delay = 32'd4; bus.adc_delay = 32'd6; bus.run_length = 32'd5;
    bus.start = 1'b1; step();
    chk("t4.armed", {61'd0, bus.state_sts}, 64'd1);
    bus.dac_delay = 32'd20; step();
    bus.trigger_in = 1'b1;
    wait_for("t4.to_wait_dac", 0, 64'd2, 20, n);
    wait_for("t4.to_wait_adc", 0, 64'd3, 40, n);
    chk("t4.latched_dac", n, 64'd4);
    n = 0;
    while (bus.state_sts == 3'd3 && n < 20) begin
      if (n == 0) begin bus.trigger_in = 1'b0; bus.start = 1'b0; end
      if (n == 2) bus.start = 1'b1;
      if (n == 3) bus.trigger_in = 1'b1;
      step();
      n++;
    end
    chk("t4.adc_dwell", n, 64'd6);
    chk("t4.run", {61'd0, bus.state_sts}, 64'd4);
    wait_for("t4.to_done", 0, 64'd5, 20, n);
    chk("t4.run_cycles", n, 64'd5);
    repeat (3) step();
    chk("t4.no_rearm", {61'd0, bus.state_sts}, 64'd5);
    bus.start = 1'b0; step();
    chk("t4.idle", {61'd0, bus.state_sts}, 64'd0);
    bus.trigger_in = 1'b0;
    repeat (4) step();

    // Simultaneous abort + fault, and fault in IDLE
    bus.dac_delay = 32'd50;
    bus.start = 1'b1; step();
    bus.trigger_in = 1'b1;
    wait_for("t5.to_wait_dac", 0, 64'd2, 20, n);
    repeat (2) step();
    bus.abort = 1'b1; bus.fault = 1'b1; step();
    chk("t5.abort_wins", {61'd0, bus.state_sts}, 64'd0);
    chk("t5.no_fault_sts", {63'd0, bus.fault_sts}, 64'd0);
    bus.abort = 1'b0; repeat (3) step();
    chk("t5.idle_fault", {61'd0, bus.state_sts}, 64'd0);
    chk("t5.idle_fault_sts", {63'd0, bus.fault_sts}, 64'd0);
    bus.fault = 1'b0; bus.start = 1'b0; bus.trigger_in = 1'b0;
    repeat (4) step();

    // Async reset mid-RUN
    bus.dac_delay = 32'd2; bus.adc_delay = 32'd2; bus.run_length = 32'd0;
    bus.start = 1'b1; step();
    bus.trigger_in = 1'b1;
    wait_for("t6.to_run", 0, 64'd4, 30, n);
    repeat (5) step();
    #1 rst_n = 1'b0;
    #1;
    chk("t6.rst_state", {61'd0, bus.state_sts}, 64'd0);
    chk("t6.rst_dac", {63'd0, bus.dac_aresetn}, 64'd0);
    chk("t6.rst_ram", {63'd0, bus.ram_aresetn}, 64'd0);
    chk("t6.rst_busy", {63'd0, bus.busy}, 64'd0);
    chk("t6.rst_cnt", {32'd0, bus.run_count}, 64'd0);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (5) step();
    chk("t6.no_auto_arm", {61'd0, bus.state_sts}, 64'd0);
    bus.start = 1'b0; step();
    bus.start = 1'b1; step();
    chk("t6.fresh_arm", {61'd0, bus.state_sts}, 64'd1);
    bus.abort = 1'b1; step();
    chk("t6.cleanup", {61'd0, bus.state_sts}, 64'd0);
    bus.abort = 1'b0; bus.start = 1'b0; bus.trigger_in = 1'b0;
    repeat (3) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Sequences the staged release of the DAC (fourier_synth/pdm) and RAM-writer resets after an acquisition trigger.
- Sits between the PS configuration registers and the peripheral reset nets: arm -> wait trigger -> release DACs -> delay -> release RAM writer -> run N cycles -> stop.
- Aborts to a safe state on watchdog fault or instant-reset request.
- Replaces the fixed RAM-writer delay with a programmable, cycle-exact one.

Parameters:
- CNT_WIDTH, 32, width of delay/run counters and of the delay/length inputs.
- SYNC_STAGES, 2, flip-flop stages on trigger_in (legal range 2-4).

Ports:
- clk  in  1  system clock (125 MHz).
- peripheral_aresetn  in  1  asynchronous, active-low reset.
- start  in  1  PS config bit; rising edge arms the sequence; low returns DONE/FAULT to IDLE.
- abort  in  1  synchronous; forces IDLE next cycle.
- trigger_in  in  1  asynchronous external trigger; synchronized internally.
- fault  in  1  synchronous watchdog-failed OR instant-reset request.
- dac_delay  in  CNT_WIDTH  cycles from trigger edge to DAC release.
- adc_delay  in  CNT_WIDTH  cycles from DAC release to RAM-writer release.
- run_length  in  CNT_WIDTH  cycles in RUN; 0 = run until abort/fault.
- dac_aresetn  out  1  reset for fourier_synth/pdm, active-low.
- ram_aresetn  out  1  reset for write_to_ram/ramwriter, active-low.
- busy  out  1  high in ARMED, WAIT_DAC, WAIT_ADC, RUN.
- done  out  1  high in DONE.
- fault_sts  out  1  high in FAULT.
- state_sts  out  3  encoded state: IDLE=0, ARMED=1, WAIT_DAC=2, WAIT_ADC=3, RUN=4, DONE=5, FAULT=6.
- run_count  out  CNT_WIDTH  cycles elapsed in RUN.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; all counters 0; synchronizer flops 0.
  - dac_aresetn=0, ram_aresetn=0, busy=0, done=0, fault_sts=0, run_count=0.
- Outputs are registered and decoded from the next state, so they change in the same edge as the state.
- start and trigger use edge detection against a one-cycle-delayed copy. Trigger edge = rising edge of the last sync stage; latency from the pin is SYNC_STAGES+1 cycles worst case.
- Latching: dac_delay, adc_delay and run_length are latched on the start edge in IDLE. Later changes have no effect until the next arm.
- IDLE -> ARMED on a start rising edge.
- ARMED -> WAIT_DAC on a trigger edge; cnt<=0.
- WAIT_DAC:
  - Each cycle: if cnt+1 >= dac_delay_l, go to WAIT_ADC with cnt<=0; else cnt++.
  - Dwell = max(dac_delay,1) cycles.
  - dac_aresetn goes 1 on entry to WAIT_ADC.
- WAIT_ADC: same rule with adc_delay_l, then RUN. ram_aresetn goes 1 on entry to RUN.
- RUN:
  - run_count increments each cycle, saturating at all-ones.
  - If run_length_l != 0 and run_count+1 >= run_length_l, go to DONE.
  - Both resets return to 0 on entry to DONE.
- DONE: done=1; stays until start=0, then IDLE.
- FAULT:
  - Entered from any state except IDLE when fault=1. Both resets 0, fault_sts=1.
  - Stays until start=0 and fault=0, then IDLE.
- Priority per cycle: abort > fault > normal transition. Fault in IDLE is ignored.
- abort: next state IDLE, resets asserted, counters cleared.
- Trigger edges outside ARMED are ignored. A start edge outside IDLE is ignored.
- A start held high after DONE does not re-arm; a new rising edge is required.
- run_count holds its value in DONE and FAULT. It clears on the ARMED entry.
- Width arithmetic: compare cnt+1 at CNT_WIDTH+1 bits so it cannot wrap at all-ones delays.
- Reset mid-operation: immediate async return to the reset values above; no partial release.

Test Plan:
- Sequence timing: reset; dac_delay=5, adc_delay=3, run_length=10; pulse start, then trigger high.
  - dac_aresetn rises exactly 5 cycles after WAIT_DAC entry; ram_aresetn 3 cycles later.
  - DONE reached after 10 RUN cycles with run_count=10; both resets 0 in DONE; IDLE one cycle after start falls.
- Zero delays: dac_delay=0, adc_delay=0, run_length=0.
  - One cycle each in WAIT_DAC and WAIT_ADC.
  - RUN persists for 1000 cycles until abort, then state_sts=0 and both resets 0 on the next cycle.
- Fault in RUN: assert fault at run_count=4.
  - Next cycle state_sts=6, fault_sts=1, both resets 0, run_count held at 4.
  - Deasserting fault with start still high stays in FAULT; start=0 gives IDLE.
- Spurious events:
  - Trigger pulses in IDLE and in WAIT_ADC change nothing.
  - A second start edge while busy is ignored.
  - Changing dac_delay while in ARMED does not alter the latched timing.
- Simultaneous events: abort and fault asserted in the same cycle in WAIT_DAC -> IDLE (fault_sts stays 0). Fault during IDLE -> no state change.
- Async reset: assert peripheral_aresetn=0 mid-RUN.
  - All outputs reach reset values without a clock edge.
  - After release, state IDLE; the sequence needs a fresh start edge.
